idt_builder: RTL and testbench
==============================

IDT_BUILDER -- requirements
Module: idt_builder

Interface
REQ-001 SHALL have parameter bs, default 16, meaning instruction buffer slots (power of two, >=2).
REQ-002 SHALL have parameter nregs, default 32, meaning architectural register count; register fields are $clog2(nregs) bits wide.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  a new instruction is presented.
REQ-006 SHALL have port in_rd, in_rs1, in_rs2  input  $clog2(nregs) each  destination and source registers.
REQ-007 SHALL have port in_ready  output  1  an insert is accepted on an edge where in_valid && in_ready.
REQ-008 SHALL have port done_valid  input  1  a buffered instruction has completed.
REQ-009 SHALL have port done_index  input  $clog2(bs)  slot of the completed instruction.
REQ-010 SHALL have port done_ready  output  1  a completion is accepted on an edge where done_valid && done_ready.
REQ-011 SHALL have port wr_en  output  1  a row write to the downstream dependency table.
REQ-012 SHALL have port buffer_index  output  $clog2(bs)  row being written.
REQ-013 SHALL have port current_idt  output  bs  row contents; bit k set = this slot waits on slot k.

Function
REQ-014 SHALL keep per slot: valid bit, rd, rs1, rs2, and a bs-bit shadow dependency row.
REQ-015 SHALL implement FSM states IDLE, CLEAR, SCAN; in_ready and done_ready SHALL be 0 outside IDLE.
REQ-016 In IDLE, done_ready SHALL be 1; in_ready SHALL be 1 only when at least one slot is invalid and done_valid is 0 (completion has priority over insert).
REQ-017 On insert accepted at edge T, the block SHALL allocate the lowest-index invalid slot s, mark it valid, and store its fields and row.
REQ-018 Row for s SHALL set bit k for every slot k valid before edge T where k.rd equals in_rs1 or in_rs2 (RAW), k.rd equals in_rd (WAW), or k.rs1/k.rs2 equals in_rd (WAR); bit s SHALL be 0; no register number is special-cased.
REQ-019 In the cycle after T: wr_en=1, buffer_index=s, current_idt=that row; wr_en SHALL be 0 in any cycle without a write.
REQ-020 On completion accepted at edge T for valid slot k: slot k SHALL become invalid at T; FSM SHALL go to CLEAR; the cycle after T SHALL show wr_en=1, buffer_index=k, current_idt=all ones.
REQ-021 CLEAR SHALL last one cycle, then SCAN SHALL visit rows j=0..bs-1, one per cycle; for each valid j with shadow bit k set, bit k SHALL be cleared and the updated row written (wr_en, buffer_index=j) in the following cycle.
REQ-022 After visiting j=bs-1, FSM SHALL return to IDLE; a completion thus blocks inserts/completions for exactly bs+1 cycles after acceptance.
REQ-023 A completion whose done_index names an invalid slot SHALL be accepted and ignored: no write, FSM stays IDLE.
REQ-024 Full buffer (all slots valid): in_ready=0; in_valid SHALL not alter state.
REQ-025 The block SHALL emit at most one row write per cycle.

Reset
REQ-026 While rst=0: all slots invalid, shadow rows 0, FSM IDLE, wr_en=0, buffer_index=0, current_idt=0, in_ready=1, done_ready=1, taking effect immediately without a clock edge.
REQ-027 Reset asserted mid-CLEAR or mid-SCAN SHALL abandon the pending write and scan with no further output.

Verification
REQ-028 Reset, insert rd=3,rs1=1,rs2=2 -> next cycle wr_en=1, buffer_index=0, current_idt=0x0000.
REQ-029 Then insert rd=5,rs1=3,rs2=0 -> buffer_index=1, current_idt=0x0001 (RAW); then rd=1,rs1=7,rs2=8 -> buffer_index=2, current_idt=0x0001 (WAR).
REQ-030 Then done_index=0 -> write row 0 = 0xFFFF, then rows 1 and 2 = 0x0000 during SCAN; in_ready and done_ready 0 for 17 cycles; in_valid held high meanwhile is not accepted.
REQ-031 Fill 16 slots -> in_ready=0; complete slot 4, wait 17 cycles, insert -> buffer_index=4.
REQ-032 done_valid and in_valid together in IDLE -> completion accepted, insert not accepted; done_index of an invalid slot -> no wr_en, done_ready stays 1.
REQ-033 Drop rst to 0 during SCAN -> wr_en=0, in_ready=1 at once; after release, next insert goes to slot 0 with row 0x0000.

Source files
------------

// File: rtl/idt_builder.sv
// -----------------------------------------------------------------------------
// idt_builder
//   Maintains an instruction buffer of bs slots. For each slot it records a
//   dependency row: bit k set means the slot must wait on slot k. Each row
//   change is streamed out as a row write to a downstream dependency table.
//
//   Inserts allocate the lowest free slot. The row records RAW, WAW and WAR
//   hazards against every slot that is already valid.
//
//   A completion frees its slot and writes that row as all ones. The block
//   then spends one CLEAR cycle and bs SCAN cycles. During SCAN it removes the
//   freed slot's bit from every dependent row and writes each row it changes.
//
// Ports
//   clk, rst         clock; asynchronous active-low reset
//   in_valid/ready   insert handshake; in_rd/in_rs1/in_rs2 register fields
//   done_valid/ready completion handshake; done_index is the completed slot
//   wr_en            one-cycle row write strobe
//   buffer_index     row being written
//   current_idt      row contents
// -----------------------------------------------------------------------------
module idt_builder #(
   parameter int unsigned bs    = 16,
   parameter int unsigned nregs = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [$clog2(nregs)-1:0] in_rd,
   input  logic [$clog2(nregs)-1:0] in_rs1,
   input  logic [$clog2(nregs)-1:0] in_rs2,
   output logic                     in_ready,
   input  logic                     done_valid,
   input  logic [$clog2(bs)-1:0]    done_index,
   output logic                     done_ready,
   output logic                     wr_en,
   output logic [$clog2(bs)-1:0]    buffer_index,
   output logic [bs-1:0]            current_idt
);

   localparam int unsigned idx_w = $clog2(bs);
   localparam int unsigned reg_w = $clog2(nregs);
   localparam logic [idx_w-1:0] last_row = idx_w'(bs - 1);

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      SCAN
   } state_t;

   state_t             state_q, state_d;
   logic [bs-1:0]      valid_q, valid_d;
   logic [reg_w-1:0]   rd_q  [bs];
   logic [reg_w-1:0]   rd_d  [bs];
   logic [reg_w-1:0]   rs1_q [bs];
   logic [reg_w-1:0]   rs1_d [bs];
   logic [reg_w-1:0]   rs2_q [bs];
   logic [reg_w-1:0]   rs2_d [bs];
   logic [bs-1:0]      row_q [bs];
   logic [bs-1:0]      row_d [bs];
   logic [idx_w-1:0]   scan_idx_q, scan_idx_d;
   logic [idx_w-1:0]   clr_slot_q, clr_slot_d;
   logic               wr_en_q, wr_en_d;
   logic [idx_w-1:0]   buffer_index_q, buffer_index_d;
   logic [bs-1:0]      current_idt_q, current_idt_d;

   logic               free_found;
   logic [idx_w-1:0]   free_idx;
   logic [bs-1:0]      new_row;

   // Lowest free slot, and the hazard row for the instruction on the inputs.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int unsigned i = 0; i < bs; i++) begin
         if (!valid_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = idx_w'(i);
         end
      end
      for (int unsigned k = 0; k < bs; k++) begin
         new_row[k] = valid_q[k] &&
                      ((rd_q[k]  == in_rs1) || (rd_q[k]  == in_rs2) ||
                       (rd_q[k]  == in_rd)  ||
                       (rs1_q[k] == in_rd)  || (rs2_q[k] == in_rd));
      end
   end

   assign done_ready   = (state_q == IDLE);
   // Completion wins over insert, so a pending completion holds off inserts.
   assign in_ready     = (state_q == IDLE) && free_found && !done_valid;
   assign wr_en        = wr_en_q;
   assign buffer_index = buffer_index_q;
   assign current_idt  = current_idt_q;

   always_comb begin
      state_d        = state_q;
      valid_d        = valid_q;
      rd_d           = rd_q;
      rs1_d          = rs1_q;
      rs2_d          = rs2_q;
      row_d          = row_q;
      scan_idx_d     = scan_idx_q;
      clr_slot_d     = clr_slot_q;
      wr_en_d        = 1'b0;
      buffer_index_d = buffer_index_q;
      current_idt_d  = current_idt_q;

      unique case (state_q)
         IDLE: begin
            if (done_valid) begin
               // A completion naming a free slot is accepted and dropped.
               if (valid_q[done_index]) begin
                  valid_d[done_index] = 1'b0;
                  clr_slot_d          = done_index;
                  wr_en_d             = 1'b1;
                  buffer_index_d      = done_index;
                  current_idt_d       = '1;
                  state_d             = CLEAR;
               end
            end else if (in_valid && in_ready) begin
               valid_d[free_idx] = 1'b1;
               rd_d[free_idx]    = in_rd;
               rs1_d[free_idx]   = in_rs1;
               rs2_d[free_idx]   = in_rs2;
               row_d[free_idx]   = new_row;
               wr_en_d           = 1'b1;
               buffer_index_d    = free_idx;
               current_idt_d     = new_row;
            end
         end
         CLEAR: begin
            scan_idx_d = '0;
            state_d    = SCAN;
         end
         SCAN: begin
            if (valid_q[scan_idx_q] && row_q[scan_idx_q][clr_slot_q]) begin
               row_d[scan_idx_q][clr_slot_q] = 1'b0;
               wr_en_d                       = 1'b1;
               buffer_index_d                = scan_idx_q;
               current_idt_d                 = row_d[scan_idx_q];
            end
            scan_idx_d = scan_idx_q + 1'b1;
            if (scan_idx_q == last_row) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         valid_q        <= '0;
         rd_q           <= '{default: '0};
         rs1_q          <= '{default: '0};
         rs2_q          <= '{default: '0};
         row_q          <= '{default: '0};
         scan_idx_q     <= '0;
         clr_slot_q     <= '0;
         wr_en_q        <= 1'b0;
         buffer_index_q <= '0;
         current_idt_q  <= '0;
      end else begin
         state_q        <= state_d;
         valid_q        <= valid_d;
         rd_q           <= rd_d;
         rs1_q          <= rs1_d;
         rs2_q          <= rs2_d;
         row_q          <= row_d;
         scan_idx_q     <= scan_idx_d;
         clr_slot_q     <= clr_slot_d;
         wr_en_q        <= wr_en_d;
         buffer_index_q <= buffer_index_d;
         current_idt_q  <= current_idt_d;
      end
   end

endmodule

// File: tb/tb_idt_builder.sv
// -----------------------------------------------------------------------------
// tb_idt_builder
//   Self-checking bench for idt_builder (bs=16, nregs=32). It combines a
//   directed vector table, hand-written corner sequences and a randomized run.
//   All three are checked against a slot-level reference model.
// -----------------------------------------------------------------------------
module tb_idt_builder;
   localparam int unsigned BS = 16;
   localparam int unsigned NR = 32;
   localparam int unsigned IW = $clog2(BS);
   localparam int unsigned RW = $clog2(NR);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic [RW-1:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic          in_ready;
   logic          done_valid = 1'b0;
   logic [IW-1:0] done_index = '0;
   logic          done_ready;
   logic          wr_en;
   logic [IW-1:0] buffer_index;
   logic [BS-1:0] current_idt;

   idt_builder #(.bs(BS), .nregs(NR)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_ready(in_ready),
      .done_valid(done_valid), .done_index(done_index), .done_ready(done_ready),
      .wr_en(wr_en), .buffer_index(buffer_index), .current_idt(current_idt)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int n_edge  = 0;

   // Reference model: slot contents and a schedule of expected row writes.
   typedef struct { int idx; logic [BS-1:0] row; } wr_t;
   wr_t           exp_wr [int];
   bit            m_valid [BS];
   int            m_rd [BS], m_rs1 [BS], m_rs2 [BS];
   logic [BS-1:0] m_dep [BS];
   int            busy_until = 0;

   typedef struct {
      bit iv; int rd, rs1, rs2; bit dv; int di;
      bit e_in_rdy, e_done_rdy, e_wr; int e_idx; logic [BS-1:0] e_row;
   } vec_t;
   vec_t tbl [22];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, n_edge);
   endtask

   function automatic bit any_free();
      for (int i = 0; i < BS; i++) if (!m_valid[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < BS; i++) begin
         m_valid[i] = 1'b0;
         m_dep[i]   = '0;
      end
      exp_wr.delete();
      busy_until = 0;
   endfunction

   function automatic void model_insert(input int rd, input int rs1, input int rs2, input int m);
      int s;
      logic [BS-1:0] row;
      s = -1;
      for (int i = BS - 1; i >= 0; i--) if (!m_valid[i]) s = i;
      row = '0;
      for (int k = 0; k < BS; k++)
         if (m_valid[k] && (m_rd[k] == rs1 || m_rd[k] == rs2 || m_rd[k] == rd ||
                            m_rs1[k] == rd || m_rs2[k] == rd))
            row[k] = 1'b1;
      m_valid[s] = 1'b1;
      m_rd[s] = rd; m_rs1[s] = rs1; m_rs2[s] = rs2;
      m_dep[s] = row;
      exp_wr[m] = '{s, row};
   endfunction

   // A completion at edge m writes its own row at m, then row j at m+2+j
   // for each dependent slot j.
   function automatic void model_complete(input int k, input int m);
      if (!m_valid[k]) return;
      m_valid[k] = 1'b0;
      exp_wr[m] = '{k, {BS{1'b1}}};
      for (int j = 0; j < BS; j++)
         if (m_valid[j] && m_dep[j][k]) begin
            m_dep[j][k] = 1'b0;
            exp_wr[m + 2 + j] = '{j, m_dep[j]};
         end
      busy_until = m + BS + 1;
   endfunction

   // Called just after a falling edge: drive inputs, check handshakes,
   // and update the model for the coming rising edge.
   task automatic drive(input bit iv, input int rd, input int rs1, input int rs2,
                        input bit dv, input int di);
      bit r_in, r_done;
      in_valid = iv; in_rd = RW'(rd); in_rs1 = RW'(rs1); in_rs2 = RW'(rs2);
      done_valid = dv; done_index = IW'(di);
      #1;
      r_done = (n_edge >= busy_until);
      r_in   = r_done && any_free() && !dv;
      chk("in_ready", in_ready, r_in);
      chk("done_ready", done_ready, r_done);
      if (dv && r_done) model_complete(di, n_edge + 1);
      else if (iv && r_in) model_insert(rd, rs1, rs2, n_edge + 1);
   endtask

   task automatic advance();
      @(posedge clk);
      n_edge++;
      @(negedge clk);
      if (!rst) begin
         chk("rst_wr_en", wr_en, 0);
         chk("rst_index", buffer_index, 0);
         chk("rst_idt", current_idt, 0);
      end else if (exp_wr.exists(n_edge)) begin
         chk("wr_en", wr_en, 1);
         chk("wr_index", buffer_index, exp_wr[n_edge].idx);
         chk("wr_row", current_idt, exp_wr[n_edge].row);
         exp_wr.delete(n_edge);
      end else begin
         chk("wr_en_quiet", wr_en, 0);
      end
   endtask

   task automatic step(input bit iv, input int rd, input int rs1, input int rs2,
                       input bit dv, input int di);
      drive(iv, rd, rs1, rs2, dv, di);
      advance();
   endtask

   task automatic do_reset();
      rst = 1'b0; in_valid = 1'b0; done_valid = 1'b0;
      #1;
      chk("reset_wr_en", wr_en, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_done_ready", done_ready, 1);
      chk("reset_index", buffer_index, 0);
      chk("reset_idt", current_idt, 0);
      model_reset();
      advance();
      advance();
      rst = 1'b1;
   endtask

   function automatic vec_t mk(input bit iv, input int rd, input int rs1, input int rs2,
                               input bit dv, input int di, input bit eir, input bit edr,
                               input bit ewr, input int eidx, input logic [BS-1:0] erow);
      vec_t v;
      v.iv = iv; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.dv = dv; v.di = di;
      v.e_in_rdy = eir; v.e_done_rdy = edr; v.e_wr = ewr; v.e_idx = eidx; v.e_row = erow;
      return v;
   endfunction

   initial begin
      // Directed table: three inserts, a completion, then a held insert that
      // is refused for the whole CLEAR+SCAN window and lands in slot 0.
      tbl[0] = mk(1, 3, 1, 2, 0, 0, 1, 1, 1, 0, 16'h0000);
      tbl[1] = mk(1, 5, 3, 0, 0, 0, 1, 1, 1, 1, 16'h0001);
      tbl[2] = mk(1, 1, 7, 8, 0, 0, 1, 1, 1, 2, 16'h0001);
      tbl[3] = mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 16'hFFFF);
      tbl[4] = mk(1, 9, 9, 9, 0, 0, 0, 0, 0, 0, 16'h0000);
      for (int i = 5; i <= 20; i++)
         tbl[i] = mk(1, 9, 9, 9, 0, 0, 0, 0, (i == 6 || i == 7), i - 5, 16'h0000);
      tbl[21] = mk(1, 9, 9, 9, 0, 0, 1, 1, 1, 0, 16'h0000);

      do_reset();
      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].iv, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].dv, tbl[i].di);
         chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_in_rdy);
         chk($sformatf("tbl%0d_done_ready", i), done_ready, tbl[i].e_done_rdy);
         advance();
         chk($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].e_wr);
         if (tbl[i].e_wr) begin
            chk($sformatf("tbl%0d_index", i), buffer_index, tbl[i].e_idx);
            chk($sformatf("tbl%0d_row", i), current_idt, tbl[i].e_row);
         end
      end

      // Full buffer: refuse inserts; free slot 4 and refill it.
      do_reset();
      for (int i = 0; i < 16; i++)
         step(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0, 0);
      drive(1, 1, 2, 3, 0, 0);
      chk("full_in_ready", in_ready, 0);
      advance();
      chk("full_no_write", wr_en, 0);
      step(0, 0, 0, 0, 1, 4);
      for (int i = 0; i < 17; i++) step(1, 4, 5, 6, 0, 0);
      step(1, 4, 5, 6, 0, 0);
      chk("refill_wr_en", wr_en, 1);
      chk("refill_index", buffer_index, 4);

      // Simultaneous insert and completion, then a completion on a free slot.
      drive(1, 2, 2, 2, 1, 7);
      chk("both_in_ready", in_ready, 0);
      advance();
      chk("both_done_index", buffer_index, 7);
      for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 7);
      chk("stale_done_no_write", wr_en, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("stale_done_ready", done_ready, 1);
      advance();

      // Reset in the middle of a scan, just as a row write is showing.
      do_reset();
      step(1, 3, 1, 2, 0, 0);
      step(1, 5, 3, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
      chk("scan_write_seen", wr_en, 1);
      do_reset();
      step(1, 6, 6, 6, 0, 0);
      chk("post_reset_index", buffer_index, 0);
      chk("post_reset_row", current_idt, 0);

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         step($urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 9) < 2, $urandom_range(0, BS - 1));
      end
      // Let any outstanding scan finish so its scheduled writes are checked.
      for (int i = 0; i < BS + 2; i++) step(0, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
